// File: rtl/w4823_fir_pkg.sv
// Shared FIR / coefficient-loader definitions.
// Holds the default geometry and the loader FSM encoding.
package w4823_fir_pkg;

  localparam int NTAPS_D = 64;
  localparam int CW_D    = 17;
  localparam int AW_D    = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/w4823_cmem_loader_if.sv
// Host coefficient stream into the loader.
// Simple valid/ready word handshake.
interface w4823_cmem_loader_if #(
  parameter int CW = 17
);

  logic          s_valid;
  logic [CW-1:0] s_data;
  logic          s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/w4823_cmem_loader.sv
// Coefficient memory loader: streams NTAPS host words
// into the FIR coefficient RAM with a one-cycle write strobe.
module w4823_cmem_loader
  import w4823_fir_pkg::*;
#(
  parameter int NTAPS = NTAPS_D,
  parameter int CW    = CW_D,
  parameter int AW    = AW_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  w4823_cmem_loader_if.slave  s,
  output logic [AW-1:0]       caddr,
  output logic [CW-1:0]       cin,
  output logic                cload,
  output logic                busy,
  output logic                done,
  output logic [AW:0]         wcount
);

  localparam logic [AW:0] LAST = (AW+1)'(NTAPS - 1);

  ld_state_e     r_state;
  ld_state_e     w_next;
  logic [AW:0]   r_idx;
  logic [AW-1:0] r_caddr;
  logic [CW-1:0] r_cin;
  logic          r_cload;
  logic          r_busy;
  logic          r_done;
  logic          r_ready;
  logic          w_xfer;
  logic          w_last;

  // abort wins over a word offered in the same cycle
  assign w_xfer = r_ready && s.s_valid && !abort;
  assign w_last = w_xfer && (r_idx == LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_next = ST_LOAD;
      ST_LOAD: begin
        if (abort)       w_next = ST_IDLE;
        else if (w_last) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_caddr <= '0;
      r_cin   <= '0;
      r_cload <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= (w_next == ST_LOAD);
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= (w_next == ST_DONE);
      r_cload <= w_xfer;
      if (r_state == ST_IDLE && start) begin
        r_idx <= '0;
      end else if (w_xfer) begin
        r_caddr <= r_idx[AW-1:0];
        r_cin   <= s.s_data;
        r_idx   <= r_idx + 1'b1;
      end
    end
  end

  assign s.s_ready = r_ready;
  assign caddr     = r_caddr;
  assign cin       = r_cin;
  assign cload     = r_cload;
  assign busy      = r_busy;
  assign done      = r_done;
  assign wcount    = r_idx;

endmodule

// File: tb/tb_w4823_cmem_loader.sv
// Randomised bench for w4823_cmem_loader against a
// word-count model, plus a NTAPS=4 build with literal words.
module tb_w4823_cmem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0;
  logic start4 = 1'b0;

  logic [5:0]  caddr;
  logic [16:0] cin;
  logic        cload, busy, done;
  logic [6:0]  wcount;
  logic [1:0]  caddr4;
  logic [16:0] cin4;
  logic        cload4, busy4, done4;
  logic [2:0]  wcount4;

  w4823_cmem_loader_if #(.CW(17)) ifc ();
  w4823_cmem_loader_if #(.CW(17)) ifc4 ();

  w4823_cmem_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s(ifc.slave), .caddr(caddr), .cin(cin), .cload(cload),
    .busy(busy), .done(done), .wcount(wcount)
  );

  w4823_cmem_loader #(.NTAPS(4), .CW(17), .AW(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(1'b0),
    .s(ifc4.slave), .caddr(caddr4), .cin(cin4), .cload(cload4),
    .busy(busy4), .done(done4), .wcount(wcount4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h exp %0h", n, cyc, got, exp);
    end
  endtask

  // model: a load is "open" while words are wanted, m_cnt words taken
  bit          m_open = 0, m_fin = 0, m_cload = 0;
  int          m_cnt = 0;
  logic [5:0]  m_caddr = '0;
  logic [16:0] m_cin = '0;
  logic [16:0] m_mem [64];

  always @(posedge clk) begin
    bit was_idle, took;
    cyc++;
    if (rst) begin
      m_open = 0; m_fin = 0; m_cload = 0; m_cnt = 0;
      m_caddr = '0; m_cin = '0;
    end else begin
      was_idle = !m_open && !m_fin;
      took = m_open && ifc.s_valid && !abort;
      m_cload = took;
      if (took) begin
        m_caddr = 6'(m_cnt);
        m_cin = ifc.s_data;
        m_mem[m_cnt] = ifc.s_data;
        m_cnt++;
      end
      m_fin = took && (m_cnt == 64);
      if (was_idle && start) begin
        m_open = 1; m_cnt = 0;
      end else if (m_open && (abort || m_fin)) begin
        m_open = 0;
      end
    end
  end

  int cload_n = 0, done_n = 0;
  logic [16:0] dmem [64];
  logic [16:0] q4 [$];
  bit          d4 [$];
  int          done4_n = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_ready", 32'(ifc.s_ready), 32'(m_open));
      chk("busy", 32'(busy), 32'(m_open || m_fin));
      chk("done", 32'(done), 32'(m_fin));
      chk("cload", 32'(cload), 32'(m_cload));
      chk("caddr", 32'(caddr), 32'(m_caddr));
      chk("cin", 32'(cin), 32'(m_cin));
      chk("wcount", 32'(wcount), 32'(m_cnt));
    end
    if (cload) begin
      cload_n++;
      dmem[caddr] = cin;
    end
    if (done) done_n++;
    if (cload4) begin
      q4.push_back(cin4);
      d4.push_back(done4);
    end
    if (done4) done4_n++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // drive one word slot; returns 1 if that edge took the word
  task automatic slot(input logic v, input logic [16:0] d, output bit hs);
    ifc.s_valid = v;
    ifc.s_data = d;
    hs = ifc.s_ready && v && !abort && !rst;
    step();
  endtask

  task automatic timeout(string n);
    checks++;
    errors++;
    $display("FAIL %s timeout cyc %0d", n, cyc);
  endtask

  initial begin
    int k, g, rdy;
    bit hs, ph;
    logic [16:0] lit4 [4];
    lit4[0] = 17'h1FFFF; lit4[1] = 17'h00000;
    lit4[2] = 17'h10000; lit4[3] = 17'h0FFFF;
    ifc.s_valid = 0; ifc.s_data = '0;
    ifc4.s_valid = 0; ifc4.s_data = '0;
    rst = 1;
    step(); step();
    chk_en = 1;
    chk("rst_wcount", 32'(wcount), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 0;
    step();

    // full back-to-back load
    cload_n = 0; done_n = 0;
    pulse_start();
    k = 0; g = 0;
    while (k < 64 && g < 400) begin
      slot(1'b1, 17'(k), hs);
      if (hs) k++;
      g++;
    end
    ifc.s_valid = 0;
    if (k < 64) timeout("full");
    step(); step();
    chk("full_wcount", 32'(wcount), 32'd64);
    chk("full_cloads", 32'(cload_n), 32'd64);
    chk("full_dones", 32'(done_n), 32'd1);
    g = 0;
    for (int i = 0; i < 64; i++) if (dmem[i] !== 17'(i)) g++;
    chk("full_mem", 32'(g), 32'd0);

    // stall with alternating valid, start poked throughout
    cload_n = 0; done_n = 0;
    pulse_start();
    k = 0; g = 0; rdy = 0; ph = 0;
    while (k < 64 && g < 400) begin
      start = 1'($urandom_range(0, 1));
      if (ifc.s_ready) rdy++;
      slot(ph, 17'($urandom), hs);
      if (hs) k++;
      ph = !ph;
      g++;
    end
    ifc.s_valid = 0;
    if (k < 64) timeout("stall");
    start = 1;
    step();
    start = 0;
    step();
    chk("stall_window", 32'(rdy), 32'd128);
    chk("stall_cloads", 32'(cload_n), 32'd64);
    chk("stall_wcount", 32'(wcount), 32'd64);
    chk("stall_idle", 32'(busy), 32'd0);
    g = 0;
    for (int i = 0; i < 64; i++) if (dmem[i] !== m_mem[i]) g++;
    chk("stall_mem", 32'(g), 32'd0);

    // abort with word 10; start+abort in idle first
    cload_n = 0; done_n = 0;
    abort = 1;
    pulse_start();
    abort = 0;
    chk("start_beats_abort", 32'(busy), 32'd1);
    k = 0; g = 0;
    while (k < 10 && g < 100) begin
      slot(1'b1, 17'(k + 100), hs);
      if (hs) k++;
      g++;
    end
    abort = 1;
    slot(1'b1, 17'h1ABCD, hs);
    abort = 0;
    ifc.s_valid = 0;
    step(); step();
    chk("abort_cloads", 32'(cload_n), 32'd10);
    chk("abort_dones", 32'(done_n), 32'd0);
    chk("abort_wcount", 32'(wcount), 32'd10);
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_caddr", 32'(caddr), 32'd9);

    // reset at word 20, then reload from 0
    pulse_start();
    k = 0; g = 0;
    while (k < 20 && g < 100) begin
      slot(1'b1, 17'($urandom), hs);
      if (hs) k++;
      g++;
    end
    rst = 1;
    slot(1'b1, 17'h15555, hs);
    rst = 0;
    ifc.s_valid = 0;
    chk("rst_mid_cin", 32'(cin), 32'd0);
    chk("rst_mid_wcount", 32'(wcount), 32'd0);
    pulse_start();
    slot(1'b1, 17'h00777, hs);
    ifc.s_valid = 0;
    chk("reload_caddr", 32'(caddr), 32'd0);
    chk("reload_cin", 32'(cin), 32'h777);
    abort = 1;
    step();
    abort = 0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      abort = ($urandom_range(0, 80) == 0);
      rst = ($urandom_range(0, 400) == 0);
      slot(1'($urandom_range(0, 3) != 0), 17'($urandom), hs);
    end
    start = 0; abort = 0; rst = 0;
    ifc.s_valid = 0;
    step(); step(); step();

    // NTAPS=4 build, full-width words
    start4 = 1;
    step();
    start4 = 0;
    k = 0; g = 0;
    while (k < 4 && g < 50) begin
      ifc4.s_valid = 1;
      ifc4.s_data = lit4[k];
      hs = ifc4.s_ready;
      step();
      if (hs) k++;
      g++;
    end
    ifc4.s_valid = 0;
    if (k < 4) timeout("n4");
    step(); step();
    chk("n4_count", 32'(q4.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < q4.size()) begin
        chk("n4_cin", 32'(q4[i]), 32'(lit4[i]));
        chk("n4_done_at", 32'(d4[i]), 32'(i == 3));
      end
    end
    chk("n4_dones", 32'(done4_n), 32'd1);
    chk("n4_wcount", 32'(wcount4), 32'd4);
    chk("n4_caddr", 32'(caddr4), 32'd3);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/w4823_cmem_loader.md
W4823_CMEM_LOADER -- requirements
Module: w4823_cmem_loader

Interface
REQ-001 Parameter NTAPS, default 64: number of coefficient words written per load.
REQ-002 Parameter CW, default 17: coefficient word width.
REQ-003 Parameter AW, default 6: coefficient address width; NTAPS SHALL be at most 2^AW.
REQ-004 clk  in  1  single clock; all outputs SHALL be registered on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 start  in  1  one-cycle request to begin a load sequence.
REQ-007 abort  in  1  terminates an active load.
REQ-008 s_valid  in  1  host coefficient word valid.
REQ-009 s_data  in  CW  host coefficient word.
REQ-010 s_ready  out  1  loader accepts s_data.
REQ-011 caddr  out  AW  coefficient memory address to FIR.
REQ-012 cin  out  CW  coefficient memory data to FIR.
REQ-013 cload  out  1  one-cycle coefficient write strobe to FIR.
REQ-014 busy  out  1  load in progress; FIR SHALL ignore its output valid while high.
REQ-015 done  out  1  one-cycle pulse on completion of a full load.
REQ-016 wcount  out  AW+1  number of words written in the current or last load.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD and DONE.
REQ-018 IDLE->LOAD on start=1; the address index and wcount SHALL be cleared on entry.
REQ-019 s_ready SHALL be 1 only in LOAD, as a registered state decode.
REQ-020 A transfer SHALL occur when s_valid=1 and s_ready=1 in the same cycle.
REQ-021 Each transfer at cycle n SHALL produce cload=1 at cycle n+1, with caddr = index and cin = s_data.
REQ-022 The index SHALL increment by one after each transfer; wcount SHALL equal index.
REQ-023 The transfer with index = NTAPS-1 SHALL cause LOAD->DONE.
REQ-024 DONE SHALL last exactly one cycle with done=1 (coincident with the final cload), then go to IDLE.
REQ-025 When cload=0, caddr and cin SHALL hold their last values; no other output changes are permitted.
REQ-026 busy SHALL be 1 in LOAD and DONE, and 0 in IDLE.
REQ-027 start SHALL be ignored in LOAD and DONE.
REQ-028 abort=1 in LOAD SHALL go to IDLE the next cycle with no done pulse, and wcount SHALL keep its value.
REQ-029 abort SHALL take priority over a simultaneous transfer: that word SHALL be discarded with no cload.
REQ-030 abort SHALL be ignored in IDLE and DONE.
REQ-031 s_valid low in LOAD SHALL stall indefinitely with no timeout and no cload.
REQ-032 start and abort asserted together in IDLE: start wins; the abort is ignored.

Reset
REQ-033 rst=1 SHALL force state IDLE and clear index, wcount, caddr, cin, cload, done and busy, overriding any other input in that cycle.
REQ-034 Reset mid-load SHALL discard the partial load; the memory contents already written remain untouched.

Structure
REQ-035 Shared package w4823_fir_pkg SHALL hold the FSM state encoding and the NTAPS, CW and AW defaults shared with W4823_FIR.
REQ-036 The block SHALL be a single module with no sub-modules; the index counter is inline.

Verification
REQ-037 Full load: start, then 64 back-to-back words 0x00000..0x0003F -> 64 cload pulses with caddr 0..63 and cin equal to the data, done one cycle at the final cload, wcount=64.
REQ-038 Stall: s_valid toggling 1/0 each cycle -> cload only on the cycle after each transfer, addresses contiguous, total 128 transfer-window cycles.
REQ-039 Abort: abort together with the transfer of word 10 -> only 10 cloads (caddr 0..9), no done, wcount=10, then IDLE.
REQ-040 Reset mid-load: rst at word 20 -> all outputs zero the next cycle, then a fresh start reloads from caddr 0.
REQ-041 start during LOAD and DONE -> no restart; index continues unchanged.
REQ-042 NTAPS=4 build: 4 words 0x1FFFF, 0, 0x10000, 0x0FFFF -> cin matches with full 17-bit width, done at the 4th cload.
